// File: rtl/axis_frame_arbiter_pkg.sv
// Shared types and helpers for the AXI4-Stream frame arbiter.
package axis_frame_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Index width that stays at least one bit wide for the two-source case.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_frame_arbiter_rr_select.sv
// Rotating priority encoder: first requester after 'last', wrapping modulo S_COUNT.
module arb_rr_select
  import axis_frame_arbiter_pkg::*;
#(
  parameter int S_COUNT = 4,
  parameter int IDXW    = idx_width(S_COUNT)
) (
  input  logic [S_COUNT-1:0] request_i,
  input  logic [IDXW-1:0]    last_i,
  output logic               found_o,
  output logic [IDXW-1:0]    index_o
);

  int cand;

  // Scan from the farthest candidate down to last+1 so the nearest requester wins.
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    cand    = 0;
    for (int k = S_COUNT; k >= 1; k--) begin
      cand = (int'(last_i) + k) % S_COUNT;
      if (request_i[cand[IDXW-1:0]]) begin
        found_o = 1'b1;
        index_o = cand[IDXW-1:0];
      end
    end
  end

endmodule

// File: rtl/axis_frame_arbiter.sv
// N-input AXI4-Stream arbiter with frame-granular round-robin grant and one registered output slice.
module axis_frame_arbiter
  import axis_frame_arbiter_pkg::*;
#(
  parameter int S_COUNT     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int LAST_ENABLE = 1,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_WIDTH  = 1,
  parameter int ID_TAG      = 1
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] input_r_TDATA,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] input_r_TKEEP,
  input  logic [S_COUNT-1:0]            input_r_TVALID,
  output logic [S_COUNT-1:0]            input_r_TREADY,
  input  logic [S_COUNT-1:0]            input_r_TLAST,
  input  logic [S_COUNT*ID_WIDTH-1:0]   input_r_TID,
  input  logic [S_COUNT*DEST_WIDTH-1:0] input_r_TDEST,
  input  logic [S_COUNT*USER_WIDTH-1:0] input_r_TUSER,
  output logic [DATA_WIDTH-1:0]         output_r_TDATA,
  output logic [KEEP_WIDTH-1:0]         output_r_TKEEP,
  output logic                          output_r_TVALID,
  input  logic                          output_r_TREADY,
  output logic                          output_r_TLAST,
  output logic [ID_WIDTH-1:0]           output_r_TID,
  output logic [DEST_WIDTH-1:0]         output_r_TDEST,
  output logic [USER_WIDTH-1:0]         output_r_TUSER,
  output logic                          grant_valid,
  output logic [idx_width(S_COUNT)-1:0] grant_index
);

  localparam int IDXW = idx_width(S_COUNT);

  arb_state_e state_q, state_d;
  logic            grant_valid_q, grant_valid_d;
  logic [IDXW-1:0] grant_index_q, grant_index_d;
  logic [IDXW-1:0] last_grant_q, last_grant_d;

  logic [DATA_WIDTH-1:0] data_q;
  logic [KEEP_WIDTH-1:0] keep_q;
  logic                  valid_q;
  logic                  last_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [DEST_WIDTH-1:0] dest_q;
  logic [USER_WIDTH-1:0] user_q;

  logic [DATA_WIDTH-1:0] srcData [S_COUNT];
  logic [KEEP_WIDTH-1:0] srcKeep [S_COUNT];
  logic [ID_WIDTH-1:0]   srcId   [S_COUNT];
  logic [DEST_WIDTH-1:0] srcDest [S_COUNT];
  logic [USER_WIDTH-1:0] srcUser [S_COUNT];

  logic            selFound;
  logic [IDXW-1:0] selIndex;
  logic            inReady;
  logic            beatAccept;
  logic            srcValid;
  logic            srcLast;
  logic [ID_WIDTH-1:0] idSel;

  for (genvar g = 0; g < S_COUNT; g++) begin : g_unpack
    assign srcData[g] = input_r_TDATA[g*DATA_WIDTH +: DATA_WIDTH];
    assign srcKeep[g] = input_r_TKEEP[g*KEEP_WIDTH +: KEEP_WIDTH];
    assign srcId[g]   = input_r_TID[g*ID_WIDTH +: ID_WIDTH];
    assign srcDest[g] = input_r_TDEST[g*DEST_WIDTH +: DEST_WIDTH];
    assign srcUser[g] = input_r_TUSER[g*USER_WIDTH +: USER_WIDTH];
  end

  arb_rr_select #(
    .S_COUNT(S_COUNT),
    .IDXW   (IDXW)
  ) u_select (
    .request_i(input_r_TVALID),
    .last_i   (last_grant_q),
    .found_o  (selFound),
    .index_o  (selIndex)
  );

  assign srcValid = input_r_TVALID[grant_index_q];
  assign srcLast  = input_r_TLAST[grant_index_q];
  assign idSel    = (ID_TAG != 0) ? ID_WIDTH'(grant_index_q) : srcId[grant_index_q];

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Requests are only looked at in IDLE; the frame owner keeps the grant through bubbles.
  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_index_d = grant_index_q;
    last_grant_d  = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (selFound) begin
          grant_index_d = selIndex;
          grant_valid_d = 1'b1;
          state_d       = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (beatAccept && (srcLast || (LAST_ENABLE == 0))) begin
          last_grant_d  = grant_index_q;
          grant_valid_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    inReady        = (state_q == ST_BUSY) && (!valid_q || output_r_TREADY);
    input_r_TREADY = '0;
    if (inReady) input_r_TREADY[grant_index_q] = 1'b1;
    beatAccept     = inReady && srcValid;
  end

  // Single output slice; a reset drops whatever beat it holds.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      grant_valid_q <= 1'b0;
      grant_index_q <= '0;
      last_grant_q  <= IDXW'(S_COUNT - 1);
      valid_q       <= 1'b0;
      data_q        <= '0;
      keep_q        <= '0;
      last_q        <= 1'b0;
      id_q          <= '0;
      dest_q        <= '0;
      user_q        <= '0;
    end else begin
      grant_valid_q <= grant_valid_d;
      grant_index_q <= grant_index_d;
      last_grant_q  <= last_grant_d;
      if (!valid_q || output_r_TREADY) begin
        valid_q <= beatAccept;
        if (beatAccept) begin
          data_q <= srcData[grant_index_q];
          keep_q <= srcKeep[grant_index_q];
          last_q <= srcLast;
          id_q   <= idSel;
          dest_q <= srcDest[grant_index_q];
          user_q <= srcUser[grant_index_q];
        end
      end
    end
  end

  assign output_r_TDATA  = data_q;
  assign output_r_TKEEP  = keep_q;
  assign output_r_TVALID = valid_q;
  assign output_r_TLAST  = last_q;
  assign output_r_TID    = id_q;
  assign output_r_TDEST  = dest_q;
  assign output_r_TUSER  = user_q;
  assign grant_valid     = grant_valid_q;
  assign grant_index     = grant_index_q;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed self-checking bench for axis_frame_arbiter (frame-lock instance plus a per-beat instance).
module tb_axis_frame_arbiter;

  localparam int S  = 4;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int IW = 8;
  localparam int TW = 8;
  localparam int UW = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [S*DW-1:0] tdata;
  logic [S*KW-1:0] tkeep;
  logic [S-1:0]    tvalid, tready, tlast;
  logic [S*IW-1:0] tid;
  logic [S*TW-1:0] tdest;
  logic [S*UW-1:0] tuser;
  logic [DW-1:0]   outData;
  logic [KW-1:0]   outKeep;
  logic            outValid, outLast, oready;
  logic [IW-1:0]   outId;
  logic [TW-1:0]   outDest;
  logic [UW-1:0]   outUser;
  logic            gv;
  logic [1:0]      gi;

  logic [S*DW-1:0] nlData;
  logic [S-1:0]    nlValid, nlReady;
  logic [DW-1:0]   nlOutData;
  logic [KW-1:0]   nlOutKeep;
  logic            nlOutValid, nlOutLast, nlOready;
  logic [IW-1:0]   nlOutId;
  logic [TW-1:0]   nlOutDest;
  logic [UW-1:0]   nlOutUser;
  logic            nlGv;
  logic [1:0]      nlGi;

  axis_frame_arbiter #(
    .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .LAST_ENABLE(1),
    .ID_WIDTH(IW), .DEST_WIDTH(TW), .USER_WIDTH(UW), .ID_TAG(1)
  ) u_dut (
    .ap_clk(clk), .ap_rst(rst),
    .input_r_TDATA(tdata), .input_r_TKEEP(tkeep), .input_r_TVALID(tvalid),
    .input_r_TREADY(tready), .input_r_TLAST(tlast), .input_r_TID(tid),
    .input_r_TDEST(tdest), .input_r_TUSER(tuser),
    .output_r_TDATA(outData), .output_r_TKEEP(outKeep), .output_r_TVALID(outValid),
    .output_r_TREADY(oready), .output_r_TLAST(outLast), .output_r_TID(outId),
    .output_r_TDEST(outDest), .output_r_TUSER(outUser),
    .grant_valid(gv), .grant_index(gi)
  );

  axis_frame_arbiter #(
    .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .LAST_ENABLE(0),
    .ID_WIDTH(IW), .DEST_WIDTH(TW), .USER_WIDTH(UW), .ID_TAG(1)
  ) u_dut_nl (
    .ap_clk(clk), .ap_rst(rst),
    .input_r_TDATA(nlData), .input_r_TKEEP({(S*KW){1'b1}}), .input_r_TVALID(nlValid),
    .input_r_TREADY(nlReady), .input_r_TLAST({S{1'b0}}), .input_r_TID({(S*IW){1'b0}}),
    .input_r_TDEST({(S*TW){1'b0}}), .input_r_TUSER({(S*UW){1'b0}}),
    .output_r_TDATA(nlOutData), .output_r_TKEEP(nlOutKeep), .output_r_TVALID(nlOutValid),
    .output_r_TREADY(nlOready), .output_r_TLAST(nlOutLast), .output_r_TID(nlOutId),
    .output_r_TDEST(nlOutDest), .output_r_TUSER(nlOutUser),
    .grant_valid(nlGv), .grant_index(nlGi)
  );

  int nChecks = 0;
  int nFail   = 0;

  int srcBase   [S];
  int srcLen    [S];
  int srcFrames [S];
  int srcBeat   [S];
  logic [S-1:0] hs;
  logic prevGv;

  logic [DW-1:0] obsData [$];
  logic [IW-1:0] obsId   [$];
  logic          obsLast [$];
  logic [TW-1:0] obsDest [$];
  int            grants  [$];

  // Present each source's current beat from the per-source frame counters.
  task automatic applyStimulus();
    for (int i = 0; i < S; i++) begin
      tvalid[i]              = (srcFrames[i] > 0);
      tdata[i*DW +: DW]      = DW'(srcBase[i] + srcBeat[i]);
      tlast[i]               = (srcBeat[i] == srcLen[i] - 1);
      tkeep[i*KW +: KW]      = 4'hF;
      tid[i*IW +: IW]        = IW'(8'h50 + i);
      tdest[i*TW +: TW]      = TW'(8'hD0 + i);
      tuser[i*UW +: UW]      = '0;
    end
  endtask

  // Observe at the falling edge: record handshakes, accepted output beats and new grants.
  task automatic sample();
    @(negedge clk);
    hs = tvalid & tready;
    if (outValid && oready) begin
      obsData.push_back(outData);
      obsId.push_back(outId);
      obsLast.push_back(outLast);
      obsDest.push_back(outDest);
    end
    if (gv && !prevGv) grants.push_back(int'(gi));
    prevGv = gv;
  endtask

  // Step the producers past the rising edge using the handshakes seen just before it.
  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < S; i++) begin
      if (hs[i]) begin
        if (srcBeat[i] == srcLen[i] - 1) begin
          srcBeat[i]   = 0;
          srcFrames[i] = srcFrames[i] - 1;
        end else begin
          srcBeat[i] = srcBeat[i] + 1;
        end
      end
    end
    applyStimulus();
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic clearAll();
    for (int i = 0; i < S; i++) begin
      srcBase[i]   = 0;
      srcLen[i]    = 1;
      srcFrames[i] = 0;
      srcBeat[i]   = 0;
    end
    oready   = 1'b1;
    nlValid  = '0;
    nlData   = '0;
    nlOready = 1'b1;
    hs       = '0;
    prevGv   = 1'b0;
    obsData.delete();
    obsId.delete();
    obsLast.delete();
    obsDest.delete();
    grants.delete();
    applyStimulus();
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearAll();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clearAll();
    for (int i = 0; i < S; i++) srcFrames[i] = 1;
    applyStimulus();
    @(negedge clk);
    nChecks++;
    if (outValid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_tvalid: got %b, expected 0", outValid); end
    nChecks++;
    if (tready !== 4'b0000) begin nFail++; $display("[TB] FAIL reset_tready: got %b, expected 0000", tready); end
    nChecks++;
    if (gv !== 1'b0) begin nFail++; $display("[TB] FAIL reset_grant_valid: got %b, expected 0", gv); end
    nChecks++;
    if (gi !== 2'd0) begin nFail++; $display("[TB] FAIL reset_grant_index: got %0d, expected 0", gi); end
    nChecks++;
    if (nlOutValid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_nl_tvalid: got %b, expected 0", nlOutValid); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    doReset();
    srcBase[0] = 32'h10; srcLen[0] = 3; srcFrames[0] = 1;
    applyStimulus();
    for (int c = 0; c < 30 && obsData.size() < 3; c++) tick();
    repeat (4) tick();
    nChecks++;
    if (obsData.size() != 3) begin nFail++; $display("[TB] FAIL single_beats: got %0d, expected 3", obsData.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < obsData.size()) begin
        nChecks++;
        if (obsData[k] !== DW'(32'h10 + k)) begin nFail++; $display("[TB] FAIL single_data%0d: got %h, expected %h", k, obsData[k], 32'h10 + k); end
        nChecks++;
        if (obsId[k] !== 8'd0) begin nFail++; $display("[TB] FAIL single_tid%0d: got %h, expected 00", k, obsId[k]); end
        nChecks++;
        if (obsLast[k] !== (k == 2)) begin nFail++; $display("[TB] FAIL single_last%0d: got %b, expected %b", k, obsLast[k], (k == 2)); end
        nChecks++;
        if (obsDest[k] !== 8'hD0) begin nFail++; $display("[TB] FAIL single_dest%0d: got %h, expected d0", k, obsDest[k]); end
      end
    end
    nChecks++;
    if (grants.size() != 1 || grants[0] != 0) begin nFail++; $display("[TB] FAIL single_grant: got %0d grants, expected one grant to 0", grants.size()); end
  endtask

  task automatic test_round_robin();
    int expGrant [5];
    int gaps [$];
    int gap;
    bit started;
    expGrant = '{0, 1, 2, 3, 0};
    doReset();
    for (int i = 0; i < S; i++) begin
      srcBase[i] = 32'h100 * (i + 1); srcLen[i] = 2; srcFrames[i] = 1;
    end
    srcFrames[0] = 2;
    applyStimulus();
    gap = 0;
    started = 1'b0;
    for (int c = 0; c < 80 && obsData.size() < 10; c++) begin
      sample();
      if (gv) begin
        if (started && gap > 0) gaps.push_back(gap);
        gap = 0;
        started = 1'b1;
      end else if (started) begin
        gap++;
      end
      advance();
    end
    nChecks++;
    if (grants.size() != 5) begin nFail++; $display("[TB] FAIL rr_grant_count: got %0d, expected 5", grants.size()); end
    for (int k = 0; k < 5; k++) begin
      if (k < grants.size()) begin
        nChecks++;
        if (grants[k] != expGrant[k]) begin nFail++; $display("[TB] FAIL rr_grant%0d: got %0d, expected %0d", k, grants[k], expGrant[k]); end
      end
    end
    nChecks++;
    if (gaps.size() != 4) begin nFail++; $display("[TB] FAIL rr_gap_count: got %0d, expected 4", gaps.size()); end
    foreach (gaps[k]) begin
      nChecks++;
      if (gaps[k] != 1) begin nFail++; $display("[TB] FAIL rr_gap%0d: got %0d idle cycles, expected 1", k, gaps[k]); end
    end
    nChecks++;
    if (obsData.size() != 10) begin nFail++; $display("[TB] FAIL rr_beats: got %0d, expected 10", obsData.size()); end
    for (int k = 0; k < 10; k++) begin
      if (k < obsData.size()) begin
        nChecks++;
        if (obsData[k] !== DW'(32'h100 * (expGrant[k/2] + 1) + (k % 2))) begin
          nFail++;
          $display("[TB] FAIL rr_data%0d: got %h, expected %h", k, obsData[k], 32'h100 * (expGrant[k/2] + 1) + (k % 2));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    doReset();
    srcBase[2] = 32'h20; srcLen[2] = 4; srcFrames[2] = 1;
    applyStimulus();
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      sample();
      if (outValid) seen = 1'b1;
      else advance();
    end
    nChecks++;
    if (!seen || outData !== 32'h20) begin nFail++; $display("[TB] FAIL bp_first: got %h, expected 00000020", outData); end
    advance();
    oready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      sample();
      nChecks++;
      if (outData !== 32'h21 || outValid !== 1'b1) begin
        nFail++; $display("[TB] FAIL bp_hold%0d: got data %h valid %b, expected 00000021 valid 1", c, outData, outValid);
      end
      nChecks++;
      if (tready !== 4'b0000) begin nFail++; $display("[TB] FAIL bp_tready%0d: got %b, expected 0000", c, tready); end
      advance();
    end
    oready = 1'b1;
    for (int c = 0; c < 30 && obsData.size() < 4; c++) tick();
    nChecks++;
    if (obsData.size() != 4) begin nFail++; $display("[TB] FAIL bp_beats: got %0d, expected 4", obsData.size()); end
    for (int k = 0; k < 4; k++) begin
      if (k < obsData.size()) begin
        nChecks++;
        if (obsData[k] !== DW'(32'h20 + k) || obsId[k] !== 8'd2) begin
          nFail++; $display("[TB] FAIL bp_data%0d: got %h tid %h, expected %h tid 02", k, obsData[k], obsId[k], 32'h20 + k);
        end
      end
    end
  endtask

  task automatic test_priority();
    int expGrant [3];
    expGrant = '{1, 3, 1};
    doReset();
    srcBase[1] = 32'h30; srcLen[1] = 2; srcFrames[1] = 2;
    srcBase[3] = 32'h70; srcLen[3] = 2;
    applyStimulus();
    tick();
    tick();
    srcFrames[3] = 1;
    applyStimulus();
    for (int c = 0; c < 60 && obsData.size() < 6; c++) tick();
    nChecks++;
    if (grants.size() != 3) begin nFail++; $display("[TB] FAIL prio_grant_count: got %0d, expected 3", grants.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < grants.size()) begin
        nChecks++;
        if (grants[k] != expGrant[k]) begin nFail++; $display("[TB] FAIL prio_grant%0d: got %0d, expected %0d", k, grants[k], expGrant[k]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    doReset();
    srcBase[0] = 32'h40; srcLen[0] = 4; srcFrames[0] = 1;
    applyStimulus();
    for (int c = 0; c < 20 && srcBeat[0] != 2; c++) tick();
    nChecks++;
    if (srcBeat[0] != 2) begin nFail++; $display("[TB] FAIL rstmid_reach: got beat %0d, expected 2", srcBeat[0]); end
    rst = 1'b1;
    sample();
    nChecks++;
    if (outValid !== 1'b0 || tready !== 4'b0000 || gv !== 1'b0) begin
      nFail++; $display("[TB] FAIL rstmid_clear: got tvalid %b tready %b gv %b, expected 0 0000 0", outValid, tready, gv);
    end
    srcBeat[0] = 0; srcFrames[0] = 1;
    srcBase[2] = 32'h60; srcLen[2] = 2; srcFrames[2] = 1; srcBeat[2] = 0;
    hs = '0;
    grants.delete();
    obsData.delete();
    obsId.delete();
    obsLast.delete();
    obsDest.delete();
    advance();
    rst = 1'b0;
    prevGv = 1'b0;
    for (int c = 0; c < 40 && obsData.size() < 6; c++) tick();
    nChecks++;
    if (grants.size() < 2 || grants[0] != 0 || grants[1] != 2) begin
      nFail++; $display("[TB] FAIL rstmid_grant: got %0d grants first %0d, expected 0 then 2", grants.size(), (grants.size() > 0) ? grants[0] : -1);
    end
    nChecks++;
    if (obsData.size() == 0 || obsData[0] !== 32'h40) begin
      nFail++; $display("[TB] FAIL rstmid_data: got %h, expected 00000040", (obsData.size() > 0) ? obsData[0] : 32'hx);
    end
  endtask

  task automatic test_no_last();
    logic [IW-1:0] nlId [$];
    logic [DW-1:0] nlD  [$];
    int expSrc [4];
    expSrc = '{0, 1, 0, 1};
    @(posedge clk);
    #1;
    nlData[0*DW +: DW] = 32'hA0;
    nlData[1*DW +: DW] = 32'hA1;
    nlValid  = 4'b0011;
    nlOready = 1'b1;
    for (int c = 0; c < 40 && nlId.size() < 4; c++) begin
      @(negedge clk);
      if (nlOutValid && nlOready) begin
        nlId.push_back(nlOutId);
        nlD.push_back(nlOutData);
      end
    end
    nChecks++;
    if (nlId.size() != 4) begin nFail++; $display("[TB] FAIL nolast_beats: got %0d, expected 4", nlId.size()); end
    for (int k = 0; k < 4; k++) begin
      if (k < nlId.size()) begin
        nChecks++;
        if (nlId[k] !== IW'(expSrc[k]) || nlD[k] !== DW'(32'hA0 + expSrc[k])) begin
          nFail++; $display("[TB] FAIL nolast_beat%0d: got tid %h data %h, expected tid %0d data %h", k, nlId[k], nlD[k], expSrc[k], 32'hA0 + expSrc[k]);
        end
      end
    end
    nlValid = '0;
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_backpressure();
    test_priority();
    test_reset_mid_frame();
    test_no_last();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
